// File: rtl/vga_timing_counter.sv
// ---------------------------------------------------------------------------
// vga_timing_counter
//
// Raster position generator for a VGA-style display. A "lead" counter runs
// PREFETCH pixel clocks ahead of the visible pixel position. Fetch logic can
// then request pixel data early. The pixel position is the lead counter
// passed through a PREFETCH-deep delay pipeline, so the two positions can
// never drift apart.
//
// A genlock request restarts the frame at a line boundary. If the request
// arrives on the last clock of a line, the restart happens at once.
// Otherwise the request is armed and applied at the next end of line.
//
// Parameters
//   X_RES, Y_RES       visible pixels per line / visible lines per frame
//   H_TOTAL, V_TOTAL   clocks per line / lines per frame, blanking included
//   PREFETCH           lead of the prefetch position in clocks (1..8)
//
// Ports
//   clk25              pixel clock, the only clock
//   rst_n              asynchronous active-low reset
//   enable             clock enable; low freezes all state
//   genlock_req        restart the frame at the next line boundary
//   pixel_position_x/y current raster position (0..H_TOTAL-1, 0..V_TOTAL-1)
//   prefetch_x/y       raster position PREFETCH clocks ahead
//   prefetch_valid     prefetch position lies inside the visible area
//   line_start         pixel x is 0 while enabled
//   frame_start        pixel position is (0,0) while enabled
//   frame_count        frames started since reset, modulo 256
//   locked             a genlock restart has been applied since reset
// ---------------------------------------------------------------------------
module vga_timing_counter #(
   parameter int X_RES    = 640,
   parameter int Y_RES    = 480,
   parameter int H_TOTAL  = 800,
   parameter int V_TOTAL  = 525,
   parameter int PREFETCH = 2
) (
   input  logic       clk25,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       genlock_req,
   output logic [9:0] pixel_position_x,
   output logic [9:0] pixel_position_y,
   output logic [9:0] prefetch_x,
   output logic [9:0] prefetch_y,
   output logic       prefetch_valid,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_count,
   output logic       locked
);

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] X_RES_W  = 10'(X_RES);
   localparam logic [9:0] Y_RES_W  = 10'(Y_RES);
   localparam logic [9:0] LEAD_RST = 10'(PREFETCH);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_ARMED = 1'b1
   } state_t;

   state_t     state_r;
   state_t     state_s;

   logic [9:0] lead_x_r;
   logic [9:0] lead_y_r;
   logic [9:0] lead_x_s;
   logic [9:0] lead_y_s;
   logic       at_line_end_s;
   logic       restart_s;

   // Delay pipeline. Stage 0 is the newest entry and holds lead-1. Stage
   // PREFETCH-1 is the oldest entry and holds the pixel position.
   logic [9:0] pipe_x_r [PREFETCH];
   logic [9:0] pipe_y_r [PREFETCH];

   // Position that the pixel output takes on the next enabled clock.
   logic [9:0] next_px_s;
   logic [9:0] next_py_s;
   logic       enter_frame_s;

   logic       locked_r;
   logic [7:0] frame_count_r;

   assign at_line_end_s = (lead_x_r == H_LAST);

   // Genlock FSM and next lead position. A restart replaces the normal
   // (0, y+1) wrap with (0, 0).
   always_comb begin
      state_s   = state_r;
      restart_s = 1'b0;
      lead_x_s  = lead_x_r;
      lead_y_s  = lead_y_r;

      case (state_r)
         ST_RUN: begin
            if (genlock_req) begin
               if (at_line_end_s) begin
                  restart_s = 1'b1;
                  state_s   = ST_RUN;
               end else begin
                  state_s   = ST_ARMED;
               end
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_ARMED: begin
            // In this state further requests are ignored; only the line end matters.
            if (at_line_end_s) begin
               restart_s = 1'b1;
               state_s   = ST_RUN;
            end else begin
               state_s   = ST_ARMED;
            end
         end
         default: begin
            state_s = ST_RUN;
         end
      endcase

      if (at_line_end_s) begin
         lead_x_s = 10'd0;
         if (restart_s) begin
            lead_y_s = 10'd0;
         end else if (lead_y_r == V_LAST) begin
            lead_y_s = 10'd0;
         end else begin
            lead_y_s = lead_y_r + 10'd1;
         end
      end else begin
         lead_x_s = lead_x_r + 10'd1;
         lead_y_s = lead_y_r;
      end
   end

   // Lead counter and FSM state register, frozen while enable is low.
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_RUN;
         lead_x_r <= LEAD_RST;
         lead_y_r <= 10'd0;
      end else if (enable) begin
         state_r  <= state_s;
         lead_x_r <= lead_x_s;
         lead_y_r <= lead_y_s;
      end
   end

   // Delay pipeline. The reset preload makes the pixel position trail the lead
   // counter by exactly PREFETCH steps from the first clock onward.
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PREFETCH; i++) begin
            pipe_x_r[i] <= 10'(PREFETCH - 1 - i);
            pipe_y_r[i] <= 10'd0;
         end
      end else if (enable) begin
         pipe_x_r[0] <= lead_x_r;
         pipe_y_r[0] <= lead_y_r;
         for (int i = 1; i < PREFETCH; i++) begin
            pipe_x_r[i] <= pipe_x_r[i-1];
            pipe_y_r[i] <= pipe_y_r[i-1];
         end
      end
   end

   generate
      if (PREFETCH == 1) begin : g_next_from_lead
         assign next_px_s = lead_x_r;
         assign next_py_s = lead_y_r;
      end else begin : g_next_from_pipe
         assign next_px_s = pipe_x_r[PREFETCH-2];
         assign next_py_s = pipe_y_r[PREFETCH-2];
      end
   endgenerate

   // A frame starts when the pixel position moves onto (0,0) from any other
   // position. A normal wrap and a genlock jump both count.
   assign enter_frame_s = (next_px_s == 10'd0) && (next_py_s == 10'd0) &&
                          !((pipe_x_r[PREFETCH-1] == 10'd0) &&
                            (pipe_y_r[PREFETCH-1] == 10'd0));

   // Genlock status, set by the first restart and cleared only by reset.
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         locked_r <= 1'b0;
      end else if (enable && restart_s) begin
         locked_r <= 1'b1;
      end
   end

   // Frame counter, which wraps modulo 256.
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         frame_count_r <= 8'd0;
      end else if (enable && enter_frame_s) begin
         frame_count_r <= frame_count_r + 8'd1;
      end
   end

   assign pixel_position_x = pipe_x_r[PREFETCH-1];
   assign pixel_position_y = pipe_y_r[PREFETCH-1];
   assign prefetch_x       = lead_x_r;
   assign prefetch_y       = lead_y_r;
   assign prefetch_valid   = (lead_x_r < X_RES_W) && (lead_y_r < Y_RES_W);
   assign line_start       = enable && (pipe_x_r[PREFETCH-1] == 10'd0);
   assign frame_start      = enable && (pipe_x_r[PREFETCH-1] == 10'd0) &&
                             (pipe_y_r[PREFETCH-1] == 10'd0);
   assign frame_count      = frame_count_r;
   assign locked           = locked_r;

endmodule
